// File: rtl/mips_chk_pkg.sv
// rtl/mips_chk_pkg.sv - shared encodings and table entry type for the retire checker
package mips_chk_pkg;

  // Expected-event kinds as loaded into the table
  typedef enum logic [1:0] {
    KIND_REG  = 2'd0,
    KIND_MEM  = 2'd1,
    KIND_PC   = 2'd2,
    KIND_RSVD = 2'd3
  } chk_kind_e;

  // Checker run states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } chk_state_e;

  // Entry fields are carried at their widest supported width; the table
  // stores only the bits the instantiating parameters actually use.
  localparam int CHK_IDX_MAX_W = 32;
  localparam int CHK_VAL_MAX_W = 64;

  typedef struct packed {
    chk_kind_e                kind;
    logic [CHK_IDX_MAX_W-1:0] idx;
    logic [CHK_VAL_MAX_W-1:0] val;
  } chk_entry_t;

endpackage

// File: rtl/chk_table.sv
// rtl/chk_table.sv - expected-event storage, synchronous write, asynchronous read
module chk_table
  import mips_chk_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  chk_entry_t    i_wentry,
  input  logic [AW-1:0] i_raddr,
  output chk_entry_t    o_rentry
);

  // Contents are deliberately not reset so a loaded table survives RST
  logic [1:0]        r_kind [DEPTH];
  logic [ADDR_W-1:0] r_idx  [DEPTH];
  logic [DATA_W-1:0] r_val  [DEPTH];

  // Store only the parameter-sized part of each field
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_kind[i_waddr] <= i_wentry.kind;
      r_idx[i_waddr]  <= i_wentry.idx[ADDR_W-1:0];
      r_val[i_waddr]  <= i_wentry.val[DATA_W-1:0];
    end
  end

  // Widen the stored entry back to the shared entry type
  always_comb begin
    o_rentry      = '0;
    o_rentry.kind = chk_kind_e'(r_kind[i_raddr]);
    o_rentry.idx  = CHK_IDX_MAX_W'(r_idx[i_raddr]);
    o_rentry.val  = CHK_VAL_MAX_W'(r_val[i_raddr]);
  end

endmodule

// File: rtl/mips_retire_checker.sv
// rtl/mips_retire_checker.sv - in-order checker of core retire events against a loaded table
module mips_retire_checker
  import mips_chk_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RIDX_W  = 5,
  parameter int ADDR_W  = 7,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   num_ent,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [1:0]               ld_kind,
  input  logic [ADDR_W-1:0]        ld_idx,
  input  logic [DATA_W-1:0]        ld_val,
  input  logic                     rf_we,
  input  logic [RIDX_W-1:0]        rf_waddr,
  input  logic [DATA_W-1:0]        rf_wdata,
  input  logic                     mem_we,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_wdata,
  input  logic                     if_stb,
  input  logic [ADDR_W-1:0]        if_pc,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timed_out,
  output logic [$clog2(DEPTH)-1:0] fail_ent,
  output logic [DATA_W-1:0]        fail_got,
  output logic [$clog2(DEPTH):0]   match_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  chk_state_e        r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;
  logic              r_timed_out;
  logic [AW-1:0]     r_fail_ent;
  logic [DATA_W-1:0] r_fail_got;
  logic [CW-1:0]     r_match_cnt;
  logic [CW-1:0]     r_num;
  logic [TW-1:0]     r_timer;

  chk_entry_t               w_wentry;
  chk_entry_t               w_ent;
  logic                     w_tbl_we;
  logic                     w_stb;
  logic                     w_idx_ok;
  logic [CHK_VAL_MAX_W-1:0] w_obs_val;
  logic                     w_hit;
  logic [CW-1:0]            w_next_cnt;
  logic                     w_last;

  // Loading is only allowed while idle and not in the cycle a run is launched
  assign w_tbl_we = ld_we && (r_state == ST_IDLE) && !start;

  // Pack the load port into a table entry
  always_comb begin
    w_wentry      = '0;
    w_wentry.kind = chk_kind_e'(ld_kind);
    w_wentry.idx  = CHK_IDX_MAX_W'(ld_idx);
    w_wentry.val  = CHK_VAL_MAX_W'(ld_val);
  end

  chk_table #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_table (
    .i_clk    (CLK),
    .i_we     (w_tbl_we),
    .i_waddr  (ld_addr),
    .i_wentry (w_wentry),
    .i_raddr  (r_match_cnt[AW-1:0]),
    .o_rentry (w_ent)
  );

  // Select the one snooped channel the current entry cares about
  always_comb begin
    w_stb     = 1'b0;
    w_idx_ok  = 1'b0;
    w_obs_val = '0;
    case (w_ent.kind)
      KIND_REG: begin
        w_stb     = rf_we;
        w_idx_ok  = (w_ent.idx[RIDX_W-1:0] == rf_waddr);
        w_obs_val = CHK_VAL_MAX_W'(rf_wdata);
      end
      KIND_MEM: begin
        w_stb     = mem_we;
        w_idx_ok  = (w_ent.idx == CHK_IDX_MAX_W'(mem_addr));
        w_obs_val = CHK_VAL_MAX_W'(mem_wdata);
      end
      KIND_PC: begin
        w_stb     = if_stb;
        w_idx_ok  = 1'b1;
        w_obs_val = CHK_VAL_MAX_W'(if_pc);
      end
      default: begin
        w_stb = 1'b0;
      end
    endcase
  end

  assign w_hit      = w_stb && w_idx_ok && (w_ent.val == w_obs_val);
  assign w_next_cnt = r_match_cnt + CW'(1);
  assign w_last     = (w_next_cnt == r_num);

  // Run FSM with timeout counter and registered verdict outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timed_out <= 1'b0;
      r_fail_ent  <= '0;
      r_fail_got  <= '0;
      r_match_cnt <= '0;
      r_num       <= '0;
      r_timer     <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_ent.kind == KIND_RSVD) begin
            r_state    <= ST_FAIL;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_fail     <= 1'b1;
            r_fail_ent <= r_match_cnt[AW-1:0];
            r_fail_got <= '0;
          end else if (w_stb) begin
            if (w_hit) begin
              r_match_cnt <= w_next_cnt;
              r_timer     <= '0;
              if (w_last) begin
                r_state <= ST_PASS;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_pass  <= 1'b1;
              end
            end else begin
              r_state    <= ST_FAIL;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_fail     <= 1'b1;
              r_fail_ent <= r_match_cnt[AW-1:0];
              r_fail_got <= w_obs_val[DATA_W-1:0];
            end
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_state     <= ST_FAIL;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_fail      <= 1'b1;
            r_timed_out <= 1'b1;
            r_fail_ent  <= r_match_cnt[AW-1:0];
            r_fail_got  <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          if (start) begin
            r_num       <= num_ent;
            r_match_cnt <= '0;
            r_timer     <= '0;
            r_fail      <= 1'b0;
            r_timed_out <= 1'b0;
            r_fail_ent  <= '0;
            r_fail_got  <= '0;
            if (num_ent == '0) begin
              r_state <= ST_PASS;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign timed_out = r_timed_out;
  assign fail_ent  = r_fail_ent;
  assign fail_got  = r_fail_got;
  assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_mips_retire_checker.sv
// tb/tb_mips_retire_checker.sv - randomized self-checking bench for mips_retire_checker
module tb_mips_retire_checker;

  localparam int DATA_W  = 32;
  localparam int RIDX_W  = 5;
  localparam int ADDR_W  = 7;
  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 16;
  localparam int AW      = 5;
  localparam int CW      = 6;

  logic              CLK = 1'b0;
  logic              RST;
  logic              start;
  logic [CW-1:0]     num_ent;
  logic              ld_we;
  logic [AW-1:0]     ld_addr;
  logic [1:0]        ld_kind;
  logic [ADDR_W-1:0] ld_idx;
  logic [DATA_W-1:0] ld_val;
  logic              rf_we;
  logic [RIDX_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              if_stb;
  logic [ADDR_W-1:0] if_pc;
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic              timed_out;
  logic [AW-1:0]     fail_ent;
  logic [DATA_W-1:0] fail_got;
  logic [CW-1:0]     match_cnt;

  mips_retire_checker #(
    .DATA_W  (DATA_W),
    .RIDX_W  (RIDX_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .num_ent   (num_ent),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_kind   (ld_kind),
    .ld_idx    (ld_idx),
    .ld_val    (ld_val),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .if_stb    (if_stb),
    .if_pc     (if_pc),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .timed_out (timed_out),
    .fail_ent  (fail_ent),
    .fail_got  (fail_got),
    .match_cnt (match_cnt)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;
  int s_edge = 0;
  int done_cyc = 0;
  bit done_seen = 1'b0;

  // Scenario description: what is loaded and what the core presents
  int          s_kind [DEPTH];
  int          s_fate [DEPTH];   // 0 event, 2 starve the entry into timeout
  int          s_gap  [DEPTH];
  logic [6:0]  s_lidx [DEPTH];
  logic [31:0] s_lval [DEPTH];
  logic [6:0]  s_pidx [DEPTH];
  logic [31:0] s_pval [DEPTH];

  always @(posedge CLK) cyc_no <= cyc_no + 1;

  // Record the edge at which a verdict first appears
  always @(posedge CLK) begin
    #2;
    if (done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc_no;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_in();
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_stb    = 1'b0;
    if_pc     = '0;
  endtask

  task automatic do_reset();
    RST   = 1'b1;
    start = 1'b0;
    ld_we = 1'b0;
    idle_in();
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  task automatic load(input int a, input int kind, input logic [6:0] idx, input logic [31:0] val);
    ld_we   = 1'b1;
    ld_addr = AW'(a);
    ld_kind = 2'(kind);
    ld_idx  = idx;
    ld_val  = val;
    cyc();
    ld_we = 1'b0;
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_ent   = CW'(n);
    done_seen = 1'b0;
    @(posedge CLK);
    #1;
    s_edge = cyc_no;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // One cycle of random traffic; the channel of 'kind' carries the event only when ev=1
  task automatic drive(input int kind, input bit ev, input logic [6:0] idx, input logic [31:0] val);
    rf_we     = 1'($urandom);
    rf_waddr  = 5'($urandom);
    rf_wdata  = $urandom;
    mem_we    = 1'($urandom);
    mem_addr  = 7'($urandom);
    mem_wdata = $urandom;
    if_stb    = 1'($urandom);
    if_pc     = 7'($urandom);
    case (kind)
      0: begin rf_we = ev; if (ev) begin rf_waddr = idx[4:0]; rf_wdata = val; end end
      1: begin mem_we = ev; if (ev) begin mem_addr = idx; mem_wdata = val; end end
      2: begin if_stb = ev; if (ev) if_pc = val[6:0]; end
      default: ;
    endcase
    cyc();
  endtask

  function automatic bit is_mismatch(input int k);
    case (s_kind[k])
      0: return (s_pidx[k][4:0] != s_lidx[k][4:0]) || (s_pval[k] != s_lval[k]);
      1: return (s_pidx[k] != s_lidx[k]) || (s_pval[k] != s_lval[k]);
      2: return s_pval[k] != s_lval[k];
      default: return 1'b1;
    endcase
  endfunction

  task automatic set_ent(input int k, input int kind, input logic [6:0] idx,
                         input logic [31:0] val, input int fate, input int gap);
    s_kind[k] = kind;
    s_lidx[k] = idx;
    s_pidx[k] = idx;
    s_lval[k] = val;
    s_pval[k] = val;
    s_fate[k] = fate;
    s_gap[k]  = gap;
  endtask

  task automatic gen_random(input int nent, input bit all_match);
    for (int k = 0; k < nent; k++) begin
      int kind;
      int r;
      int g;
      kind = (!all_match && $urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
      r    = all_match ? 10 : int'($urandom_range(0, 29));
      case ($urandom_range(0, 3))
        0:       g = 0;
        1:       g = TIMEOUT - 1;
        default: g = int'($urandom_range(0, TIMEOUT - 1));
      endcase
      set_ent(k, kind, 7'($urandom), (kind == 2) ? 32'(7'($urandom)) : $urandom,
              (r == 0) ? 2 : 0, g);
      if (r >= 1 && r <= 3) begin
        if (kind == 2) s_pval[k] = s_lval[k] ^ 32'($urandom_range(1, 127));
        else if ($urandom_range(0, 1) == 0) s_pval[k] = s_lval[k] ^ (32'h1 << $urandom_range(0, 31));
        else if (kind == 0) s_pidx[k] = s_lidx[k] ^ 7'($urandom_range(1, 31));
        else s_pidx[k] = s_lidx[k] ^ 7'($urandom_range(1, 127));
      end
    end
  endtask

  // Load, predict, run and judge one scenario of nent entries
  task automatic run_scenario(input string tag, input int nent);
    int t;
    int fk;
    int cnt;
    bit to;
    logic [31:0] got;
    do_reset();
    for (int k = 0; k < nent; k++) load(k, s_kind[k], s_lidx[k], s_lval[k]);
    t = 0; fk = -1; cnt = 0; to = 1'b0; got = '0;
    for (int k = 0; k < nent; k++) begin
      if (s_kind[k] == 3) begin t += 1; fk = k; break; end
      if (s_fate[k] == 2) begin t += TIMEOUT; fk = k; to = 1'b1; break; end
      t += s_gap[k] + 1;
      if (is_mismatch(k)) begin fk = k; got = s_pval[k]; break; end
      cnt++;
    end
    do_start(nent);
    for (int k = 0; k < nent; k++) begin
      if (s_kind[k] == 3) begin drive(3, 1'b0, '0, '0); break; end
      if (s_fate[k] == 2) begin
        for (int i = 0; i < TIMEOUT; i++) drive(s_kind[k], 1'b0, '0, '0);
        break;
      end
      for (int i = 0; i < s_gap[k]; i++) drive(s_kind[k], 1'b0, '0, '0);
      drive(s_kind[k], 1'b1, s_pidx[k], s_pval[k]);
      if (is_mismatch(k)) break;
    end
    idle_in();
    cyc();
    cyc();
    check({tag, ".verdict_edge"}, done_seen ? 64'(done_cyc - s_edge) : 64'hFFFF, 64'(t));
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".pass"}, 64'(pass), 64'(fk < 0));
    check({tag, ".fail"}, 64'(fail), 64'(fk >= 0));
    check({tag, ".timed_out"}, 64'(timed_out), 64'(to));
    check({tag, ".match_cnt"}, 64'(match_cnt), 64'(cnt));
    if (fk >= 0) begin
      check({tag, ".fail_ent"}, 64'(fail_ent), 64'(fk));
      check({tag, ".fail_got"}, 64'(fail_got), 64'(got));
    end
  endtask

  initial begin
    RST     = 1'b1;
    start   = 1'b0;
    num_ent = '0;
    ld_we   = 1'b0;
    ld_addr = '0;
    ld_kind = '0;
    ld_idx  = '0;
    ld_val  = '0;
    idle_in();
    @(negedge CLK);
    do_reset();
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.pass", 64'(pass), 64'd0);
    check("reset.fail", 64'(fail), 64'd0);
    check("reset.timed_out", 64'(timed_out), 64'd0);
    check("reset.fail_ent", 64'(fail_ent), 64'd0);
    check("reset.fail_got", 64'(fail_got), 64'd0);
    check("reset.match_cnt", 64'(match_cnt), 64'd0);

    // Three register writes four cycles apart
    set_ent(0, 0, 7'd1, 32'd5, 0, 3);
    set_ent(1, 0, 7'd2, 32'd7, 0, 3);
    set_ent(2, 0, 7'd3, 32'd12, 0, 3);
    run_scenario("reg3", 3);

    // Register data mismatch
    set_ent(0, 0, 7'd4, 32'd9, 0, 2);
    s_pval[0] = 32'd8;
    run_scenario("regbad", 1);

    // Store found among unrelated traffic, then starved into timeout
    set_ent(0, 1, 7'd23, 32'd42, 0, 5);
    run_scenario("mem", 1);
    set_ent(0, 1, 7'd23, 32'd42, 2, 0);
    run_scenario("memto", 1);

    // Taken branch expected but fall-through fetched
    set_ent(0, 2, 7'd0, 32'd10, 0, 2);
    set_ent(1, 2, 7'd0, 32'd14, 0, 2);
    s_pval[1] = 32'd11;
    run_scenario("pc", 2);

    // Full table, every entry matching
    gen_random(DEPTH, 1'b1);
    run_scenario("full", DEPTH);

    // Zero-entry run passes on the following cycle
    do_reset();
    do_start(0);
    check("zero.pass", 64'(pass), 64'd1);
    check("zero.done", 64'(done), 64'd1);
    check("zero.busy", 64'(busy), 64'd0);

    // Table writes during a run are dropped
    do_reset();
    load(0, 0, 7'd1, 32'd5);
    do_start(1);
    load(0, 0, 7'd1, 32'd99);
    drive(0, 1'b1, 7'd1, 32'd5);
    idle_in();
    cyc();
    check("ldrun.pass", 64'(pass), 64'd1);

    // Table write in the start cycle is dropped
    do_reset();
    load(0, 0, 7'd2, 32'd5);
    start = 1'b1; num_ent = CW'(1);
    ld_we = 1'b1; ld_addr = '0; ld_kind = 2'd0; ld_idx = 7'd2; ld_val = 32'd77;
    cyc();
    start = 1'b0; ld_we = 1'b0;
    drive(0, 1'b1, 7'd2, 32'd5);
    idle_in();
    cyc();
    check("ldstart.pass", 64'(pass), 64'd1);

    // Reset mid-run keeps the table; a fresh run rechecks it
    do_reset();
    load(0, 0, 7'd1, 32'd5);
    load(1, 0, 7'd2, 32'd7);
    load(2, 0, 7'd3, 32'd12);
    do_start(3);
    drive(0, 1'b1, 7'd1, 32'd5);
    drive(0, 1'b1, 7'd2, 32'd7);
    check("midrst.cnt_before", 64'(match_cnt), 64'd2);
    RST = 1'b1;
    idle_in();
    cyc();
    RST = 1'b0;
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    check("midrst.match_cnt", 64'(match_cnt), 64'd0);
    do_start(3);
    drive(0, 1'b1, 7'd1, 32'd5);
    drive(0, 1'b1, 7'd2, 32'd7);
    drive(0, 1'b1, 7'd3, 32'd12);
    idle_in();
    cyc();
    check("midrst.pass", 64'(pass), 64'd1);
    check("midrst.match_cnt_after", 64'(match_cnt), 64'd3);

    // Random scenarios
    for (int n = 0; n < 30; n++) begin
      int nent;
      nent = int'($urandom_range(1, 12));
      gen_random(nent, 1'b0);
      run_scenario($sformatf("rnd%0d", n), nent);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
